// File: rtl/mux_arb_pkg.sv
// Shared sizes and types for the round-robin mux-select arbiter.
package mux_arb_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [NUM_CH-1:0] req_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mux_rr_sel_arbiter_rr_pick.sv
// Combinational round-robin pick: the first set request at or after ptr, wrapping mod NUM_CH.
module rr_pick
  import mux_arb_pkg::*;
(
  input  req_t req,
  input  sel_t ptr,
  output logic found,
  output sel_t win
);

  logic [2*NUM_CH-1:0] dbl;
  req_t                rot;
  sel_t                off;

  // Rotate so ptr lands at bit 0, find the lowest set bit, then rotate the index back.
  always_comb begin
    dbl   = {req, req};
    rot   = req_t'(dbl >> ptr);
    found = |rot;
    off   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) off = sel_t'(i);
    end
    win = sel_t'(off + ptr);
  end

endmodule

// File: rtl/mux_rr_sel_arbiter.sv
// Round-robin arbiter driving the 4-to-1 mux select; each decision is held until valid/ready.
// Optional burst mode (`define MUX_ARB_BURST_EN) adds a 'last' input; only hs & last releases a grant.
module mux_rr_sel_arbiter
  import mux_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              out_ready,
`ifdef MUX_ARB_BURST_EN
  input  logic              last,
`endif
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] grant,
  output logic              out_valid
);

  arb_state_t state, state_n;
  sel_t       ptr, ptr_n, sel_n;
  req_t       grant_n;
  logic       valid_n;

  logic       hs;
  logic       done;
  req_t       pick_req;
  sel_t       pick_ptr;
  sel_t       win;
  logic       found;

  assign hs = out_valid & out_ready;

`ifdef MUX_ARB_BURST_EN
  assign done = hs & last;
`else
  assign done = hs;
`endif

  // While granting, the next pick starts after the served channel and ignores its request.
  always_comb begin
    pick_req = req;
    pick_ptr = ptr;
    if (state == GRANT) begin
      pick_req = req & ~grant;
      pick_ptr = sel_t'(sel + 1'b1);
    end
  end

  rr_pick u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .found (found),
    .win   (win)
  );

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel;
    grant_n = grant;
    valid_n = out_valid;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          sel_n   = win;
          grant_n = req_t'(1) << win;
          valid_n = 1'b1;
        end
      end
      GRANT: begin
        if (done) begin
          ptr_n = pick_ptr;
          if (found) begin
            sel_n   = win;
            grant_n = req_t'(1) << win;
          end else begin
            state_n = IDLE;
            grant_n = '0;
            valid_n = 1'b0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      grant     <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      sel       <= sel_n;
      grant     <= grant_n;
      out_valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_mux_rr_sel_arbiter.sv
// Scoreboard bench for mux_rr_sel_arbiter: a cycle-level round-robin model predicts outputs.
module tb_mux_rr_sel_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       out_ready;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       out_valid;
`ifdef MUX_ARB_BURST_EN
  logic       last;
`endif

  typedef struct packed {
    logic       v;
    logic [1:0] s;
    logic [3:0] g;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model state
  bit m_valid;
  int m_sel;
  int m_ptr;

  mux_rr_sel_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .out_ready (out_ready),
`ifdef MUX_ARB_BURST_EN
    .last      (last),
`endif
    .sel       (sel),
    .grant     (grant),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // First requesting channel found by walking p, p+1, ... modulo 4.
  function automatic int first_at(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (p + k) % 4;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic void model_reset();
    m_valid = 0;
    m_sel   = 0;
    m_ptr   = 0;
  endfunction

  function automatic void model_edge(input logic [3:0] r, input logic rd);
    logic [3:0] mr;
    if (!m_valid) begin
      if (r != 4'b0) begin
        m_sel   = first_at(r, m_ptr);
        m_valid = 1;
      end
    end else if (rd) begin
      m_ptr = (m_sel + 1) % 4;
      mr    = r;
      mr[m_sel] = 1'b0;
      if (mr != 4'b0) m_sel = first_at(mr, m_ptr);
      else            m_valid = 0;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.v = m_valid;
    e.s = 2'(m_sel);
    e.g = m_valid ? 4'(1 << m_sel) : 4'b0;
    return e;
  endfunction

  // Apply inputs for one cycle, advance the model across the edge, queue the expectation.
  task automatic step(input logic [3:0] r, input logic rd);
    req       = r;
    out_ready = rd;
    @(posedge clk);
    #1;
    model_edge(r, rd);
    q.push_back(model_out());
  endtask

  // Monitor: compare registered outputs mid-cycle against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("out_valid", int'(out_valid), int'(e.v));
        check("sel",       int'(sel),       int'(e.s));
        check("grant",     int'(grant),     int'(e.g));
      end
    end
  end

  initial begin
    logic [3:0] cur;
    logic       rd;
    bit         hs;
    int         srv;

    rst_n     = 1'b1;
    req       = 4'b1111;
    out_ready = 1'b0;
`ifdef MUX_ARB_BURST_EN
    last      = 1'b1;
`endif
    model_reset();

    // Reset with every channel requesting: outputs clear without a clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", int'(out_valid), 0);
    check("rst_async_sel",   int'(sel),       0);
    check("rst_async_grant", int'(grant),     0);
    #20;
    check("rst_hold_valid", int'(out_valid), 0);
    check("rst_hold_grant", int'(grant),     0);
    req = 4'b0000;
    #2 rst_n = 1'b1;

    // Single requester, stalled downstream, then one accept
    for (int i = 0; i < 6; i++) step(4'b0100, 1'b0);
    step(4'b0100, 1'b1);
    step(4'b0000, 1'b0);

    // Pointer now sits at 3: ch0 then ch1 must win, ch2/ch3 idle
    step(4'b0011, 1'b1);
    step(4'b0011, 1'b1);
    step(4'b0010, 1'b1);
    step(4'b0000, 1'b1);

    // Reset in the middle of a held grant on ch2
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    #5;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_sel",   int'(sel),       0);
    check("midrst_grant", int'(grant),     0);
    model_reset();
    req = 4'b1111;
    #6 rst_n = 1'b1;

    // All requesting with downstream always ready: strict rotation
    cur = 4'b1111;
    for (int i = 0; i < 9; i++) step(cur, 1'b1);

    // Randomised traffic; requests are held until served
    for (int i = 0; i < 400; i++) begin
      rd  = ($urandom_range(0, 3) != 0);
      hs  = m_valid && rd;
      srv = m_sel;
      step(cur, rd);
      if (hs) cur[srv] = 1'($urandom_range(0, 1));
      for (int c = 0; c < 4; c++) begin
        if (!cur[c] && $urandom_range(0, 2) == 0) cur[c] = 1'b1;
      end
    end

    // Drain outstanding requests, bounded
    for (int i = 0; i < 20; i++) begin
      if (!m_valid && cur == 4'b0) break;
      hs  = m_valid;
      srv = m_sel;
      step(cur, 1'b1);
      if (hs) cur[srv] = 1'b0;
    end
    check("drained_model", int'(m_valid), 0);
    step(4'b0000, 1'b1);

    @(negedge clk);
    @(negedge clk);
    check("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
